// File: rtl/spi_cp0_master.sv
// spi_cp0_master: SPI master behind a coprocessor-style register bank.
// The CPU reaches it through MTC0/MFC0 moves (ctrl/addr/wd/data_out).
// It has TX/RX FIFOs, all four SPI modes, a programmable half-period divider,
// N_CS chip selects and back-to-back frames.
// Optional feature: define SPI_LOOPBACK_EN to implement CTRL bit 7 (LOOP).
// When LOOP is set, the receiver samples the internal mosi instead of miso.

`ifndef W_SPI_CTRL
`define W_SPI_CTRL 2
`endif
`ifndef MT
`define MT 2'd1
`endif
`ifndef MF
`define MF 2'd2
`endif
`ifndef W_REG
`define W_REG 5
`endif

module spi_cp0_master #(
    parameter int unsigned W_DATA  = 32,
    parameter int unsigned W_FRAME = 8,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned N_CS    = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [`W_SPI_CTRL-1:0] ctrl,
    input  logic [`W_REG-1:0]      addr,
    input  logic [W_DATA-1:0]      wd,
    output logic [W_DATA-1:0]      data_out,
    output logic                   sclk,
    output logic                   mosi,
    input  logic                   miso,
    output logic [N_CS-1:0]        cs_n,
    output logic                   busy
);

    localparam int unsigned WR    = `W_REG;
    localparam int unsigned W_PTR = $clog2(DEPTH);
    localparam int unsigned W_CNT = W_PTR + 1;
    localparam int unsigned W_EC  = $clog2(2 * W_FRAME);

    localparam logic [WR-1:0]    A_CTRL   = WR'(0);
    localparam logic [WR-1:0]    A_DIV    = WR'(1);
    localparam logic [WR-1:0]    A_TX     = WR'(2);
    localparam logic [WR-1:0]    A_RX     = WR'(3);
    localparam logic [WR-1:0]    A_STATUS = WR'(4);
    localparam logic [W_EC-1:0]  EC_LAST  = W_EC'(2 * W_FRAME - 1);
    localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_LEAD, S_XFER, S_TRAIL} state_t;

    // Current bit presented on mosi for the chosen bit order.
    function automatic logic out_bit(input logic [W_FRAME-1:0] sh, input logic lsb);
        return lsb ? sh[0] : sh[W_FRAME-1];
    endfunction

    // Advance the TX shift register by one bit in the chosen bit order.
    function automatic logic [W_FRAME-1:0] shift_out(input logic [W_FRAME-1:0] sh, input logic lsb);
        return lsb ? {1'b0, sh[W_FRAME-1:1]} : {sh[W_FRAME-2:0], 1'b0};
    endfunction

    state_t state_q, state_d;

    // CPU-visible configuration
    logic en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
    logic [2:0] cs_sel_q, cs_sel_d;
    logic [7:0] div_q, div_d;
`ifdef SPI_LOOPBACK_EN
    logic loop_q, loop_d;
`endif

    // Per-frame snapshot of the configuration
    logic lat_cpol_q, lat_cpol_d, lat_cpha_q, lat_cpha_d, lat_lsb_q, lat_lsb_d;
    logic [2:0] lat_cs_q, lat_cs_d;
    logic [7:0] lat_div_q, lat_div_d;

    // Shift engine
    logic [7:0]         div_cnt_q, div_cnt_d;
    logic [W_EC-1:0]    edge_cnt_q, edge_cnt_d;
    logic [W_FRAME-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
    logic               sclk_q, sclk_d, mosi_q, mosi_d;
    logic [N_CS-1:0]    cs_n_q, cs_n_d;

    // FIFOs and sticky flags
    logic [W_FRAME-1:0] tx_mem_q [DEPTH];
    logic [W_FRAME-1:0] tx_mem_d [DEPTH];
    logic [W_FRAME-1:0] rx_mem_q [DEPTH];
    logic [W_FRAME-1:0] rx_mem_d [DEPTH];
    logic [W_PTR-1:0]   tx_rd_q, tx_rd_d, tx_wr_q, tx_wr_d;
    logic [W_PTR-1:0]   rx_rd_q, rx_rd_d, rx_wr_q, rx_wr_d;
    logic [W_CNT-1:0]   tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
    logic               tx_ovf_q, tx_ovf_d, rx_ovf_q, rx_ovf_d;

    logic wr_en, rd_en, tx_full, tx_empty, rx_full, rx_empty;
    logic tx_push_req, tx_pop, tx_do_push;
    logic rx_pop_req, rx_push, rx_do_push, rx_do_pop, rx_bypass;
    logic [W_FRAME-1:0] tx_head, rx_push_data, rx_head;
    logic tick, sample_bit, odd_edge, sample_edge, shift_edge;
    logic unused_wd;

    assign wr_en       = (ctrl == `MT);
    assign rd_en       = (ctrl == `MF);
    assign tx_full     = (tx_cnt_q == CNT_FULL);
    assign tx_empty    = (tx_cnt_q == '0);
    assign rx_full     = (rx_cnt_q == CNT_FULL);
    assign rx_empty    = (rx_cnt_q == '0);
    assign tx_push_req = wr_en && (addr == A_TX);
    assign rx_pop_req  = rd_en && (addr == A_RX);
    assign tx_head     = tx_mem_q[tx_rd_q];
    assign tick        = (div_cnt_q == lat_div_q);
    assign unused_wd   = ^wd;

`ifdef SPI_LOOPBACK_EN
    assign sample_bit = loop_q ? mosi_q : miso;
`else
    assign sample_bit = miso;
`endif

    assign sclk = sclk_q;
    assign mosi = mosi_q;
    assign cs_n = cs_n_q;
    assign busy = (state_q != S_IDLE);

    // CPU writes to CTRL and DIV.
    always_comb begin
        en_d     = en_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        lsb_d    = lsb_q;
        cs_sel_d = cs_sel_q;
        div_d    = div_q;
`ifdef SPI_LOOPBACK_EN
        loop_d   = loop_q;
`endif
        if (wr_en && addr == A_CTRL) begin
            en_d     = wd[0];
            cpol_d   = wd[1];
            cpha_d   = wd[2];
            lsb_d    = wd[3];
            cs_sel_d = wd[6:4];
`ifdef SPI_LOOPBACK_EN
            loop_d   = wd[7];
`endif
        end
        if (wr_en && addr == A_DIV) begin
            div_d = wd[7:0];
        end
    end

    // Frame sequencer: next state, shift registers and registered pin values.
    always_comb begin
        state_d    = state_q;
        lat_cpol_d = lat_cpol_q;
        lat_cpha_d = lat_cpha_q;
        lat_lsb_d  = lat_lsb_q;
        lat_cs_d   = lat_cs_q;
        lat_div_d  = lat_div_q;
        div_cnt_d  = tick ? 8'd0 : div_cnt_q + 8'd1;
        edge_cnt_d = edge_cnt_q;
        tx_sh_d    = tx_sh_q;
        rx_sh_d    = rx_sh_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        tx_pop     = 1'b0;
        rx_push    = 1'b0;
        odd_edge    = (edge_cnt_q[0] == 1'b0);
        sample_edge = (odd_edge != lat_cpha_q);
        shift_edge  = !sample_edge && (edge_cnt_q != EC_LAST);

        if (state_q != S_IDLE && !en_q) begin
            // EN dropped mid-frame: abandon the frame, leave the FIFOs alone
            state_d   = S_IDLE;
            div_cnt_d = 8'd0;
            sclk_d    = cpol_q;
            mosi_d    = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    div_cnt_d  = 8'd0;
                    edge_cnt_d = '0;
                    sclk_d     = cpol_q;
                    mosi_d     = 1'b0;
                    if (en_q && !tx_empty) begin
                        tx_pop     = 1'b1;
                        state_d    = S_LEAD;
                        lat_cpol_d = cpol_q;
                        lat_cpha_d = cpha_q;
                        lat_lsb_d  = lsb_q;
                        lat_cs_d   = cs_sel_q;
                        lat_div_d  = div_q;
                        rx_sh_d    = '0;
                        if (!cpha_q) begin
                            mosi_d  = out_bit(tx_head, lsb_q);
                            tx_sh_d = shift_out(tx_head, lsb_q);
                        end else begin
                            tx_sh_d = tx_head;
                        end
                    end
                end
                S_LEAD: begin
                    if (tick) begin
                        state_d    = S_XFER;
                        edge_cnt_d = '0;
                    end
                end
                S_XFER: begin
                    // Each half-period ends with an sclk edge; the last one
                    // coincides with leaving XFER and restores idle polarity.
                    if (tick) begin
                        sclk_d = !sclk_q;
                        if (sample_edge) begin
                            rx_sh_d = lat_lsb_q ? {sample_bit, rx_sh_q[W_FRAME-1:1]}
                                                : {rx_sh_q[W_FRAME-2:0], sample_bit};
                        end
                        if (shift_edge) begin
                            mosi_d  = out_bit(tx_sh_q, lat_lsb_q);
                            tx_sh_d = shift_out(tx_sh_q, lat_lsb_q);
                        end
                        if (edge_cnt_q == EC_LAST) begin
                            state_d = S_TRAIL;
                            rx_push = 1'b1;
                        end else begin
                            edge_cnt_d = edge_cnt_q + W_EC'(1);
                        end
                    end
                end
                S_TRAIL: begin
                    if (tick) begin
                        if (en_q && !tx_empty) begin
                            // Back-to-back: skip LEAD, keep the chip select low
                            tx_pop     = 1'b1;
                            state_d    = S_XFER;
                            edge_cnt_d = '0;
                            rx_sh_d    = '0;
                            if (!lat_cpha_q) begin
                                mosi_d  = out_bit(tx_head, lat_lsb_q);
                                tx_sh_d = shift_out(tx_head, lat_lsb_q);
                            end else begin
                                tx_sh_d = tx_head;
                            end
                        end else begin
                            state_d = S_IDLE;
                            sclk_d  = cpol_q;
                            mosi_d  = 1'b0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        rx_push_data = rx_sh_d;
        for (int unsigned i = 0; i < N_CS; i++) begin
            cs_n_d[i] = !((state_d != S_IDLE) && (lat_cs_d == 3'(i)));
        end
    end

    // FIFO bookkeeping and sticky overflow flags.
    always_comb begin
        tx_mem_d = tx_mem_q;
        rx_mem_d = rx_mem_q;
        tx_rd_d  = tx_rd_q;
        tx_wr_d  = tx_wr_q;
        tx_cnt_d = tx_cnt_q;
        rx_rd_d  = rx_rd_q;
        rx_wr_d  = rx_wr_q;
        rx_cnt_d = rx_cnt_q;
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;

        tx_do_push = tx_push_req && (!tx_full || tx_pop);
        // Empty RX with a push and a pop together: the frame passes straight
        // through to data_out and the storage is untouched.
        rx_bypass  = rx_empty && rx_push && rx_pop_req;
        rx_do_pop  = rx_pop_req && !rx_empty;
        rx_do_push = rx_push && !rx_bypass && (!rx_full || rx_do_pop);

        if (tx_do_push) begin
            tx_mem_d[tx_wr_q] = wd[W_FRAME-1:0];
            tx_wr_d = tx_wr_q + W_PTR'(1);
        end
        if (tx_pop) begin
            tx_rd_d = tx_rd_q + W_PTR'(1);
        end
        case ({tx_do_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + W_CNT'(1);
            2'b01:   tx_cnt_d = tx_cnt_q - W_CNT'(1);
            default: tx_cnt_d = tx_cnt_q;
        endcase

        if (rx_do_push) begin
            rx_mem_d[rx_wr_q] = rx_push_data;
            rx_wr_d = rx_wr_q + W_PTR'(1);
        end
        if (rx_do_pop) begin
            rx_rd_d = rx_rd_q + W_PTR'(1);
        end
        case ({rx_do_push, rx_do_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + W_CNT'(1);
            2'b01:   rx_cnt_d = rx_cnt_q - W_CNT'(1);
            default: rx_cnt_d = rx_cnt_q;
        endcase

        if (wr_en && addr == A_STATUS && wd[5]) tx_ovf_d = 1'b0;
        if (wr_en && addr == A_STATUS && wd[6]) rx_ovf_d = 1'b0;
        if (tx_push_req && tx_full && !tx_pop) tx_ovf_d = 1'b1;
        if (rx_push && rx_full && !rx_do_pop) rx_ovf_d = 1'b1;
    end

    // Combinational read port for MF moves.
    always_comb begin
        rx_head  = rx_bypass ? rx_push_data : (rx_empty ? '0 : rx_mem_q[rx_rd_q]);
        data_out = '0;
        if (rd_en) begin
            case (addr)
`ifdef SPI_LOOPBACK_EN
                A_CTRL:   data_out = W_DATA'({loop_q, cs_sel_q, lsb_q, cpha_q, cpol_q, en_q});
`else
                A_CTRL:   data_out = W_DATA'({1'b0, cs_sel_q, lsb_q, cpha_q, cpol_q, en_q});
`endif
                A_DIV:    data_out = W_DATA'(div_q);
                A_RX:     data_out = W_DATA'(rx_head);
                A_STATUS: data_out = W_DATA'({rx_ovf_q, tx_ovf_q, rx_empty, rx_full,
                                              tx_empty, tx_full, busy});
                default:  data_out = '0;
            endcase
        end
    end

    // All state, asynchronously reset to idle pins and empty FIFOs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            en_q       <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            cs_sel_q   <= '0;
            div_q      <= '0;
`ifdef SPI_LOOPBACK_EN
            loop_q     <= 1'b0;
`endif
            lat_cpol_q <= 1'b0;
            lat_cpha_q <= 1'b0;
            lat_lsb_q  <= 1'b0;
            lat_cs_q   <= '0;
            lat_div_q  <= '0;
            div_cnt_q  <= '0;
            edge_cnt_q <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            tx_mem_q   <= '{default: '0};
            rx_mem_q   <= '{default: '0};
            tx_rd_q    <= '0;
            tx_wr_q    <= '0;
            tx_cnt_q   <= '0;
            rx_rd_q    <= '0;
            rx_wr_q    <= '0;
            rx_cnt_q   <= '0;
            tx_ovf_q   <= 1'b0;
            rx_ovf_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            cs_sel_q   <= cs_sel_d;
            div_q      <= div_d;
`ifdef SPI_LOOPBACK_EN
            loop_q     <= loop_d;
`endif
            lat_cpol_q <= lat_cpol_d;
            lat_cpha_q <= lat_cpha_d;
            lat_lsb_q  <= lat_lsb_d;
            lat_cs_q   <= lat_cs_d;
            lat_div_q  <= lat_div_d;
            div_cnt_q  <= div_cnt_d;
            edge_cnt_q <= edge_cnt_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_mem_q   <= tx_mem_d;
            rx_mem_q   <= rx_mem_d;
            tx_rd_q    <= tx_rd_d;
            tx_wr_q    <= tx_wr_d;
            tx_cnt_q   <= tx_cnt_d;
            rx_rd_q    <= rx_rd_d;
            rx_wr_q    <= rx_wr_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_ovf_q   <= tx_ovf_d;
            rx_ovf_q   <= rx_ovf_d;
        end
    end

endmodule

// File: tb/tb_spi_cp0_master.sv
// Directed bench for spi_cp0_master (W_FRAME=8, DEPTH=4, N_CS=2).
// Loopback is made externally (miso driven from mosi), so the same
// expectations hold with or without SPI_LOOPBACK_EN.

`ifndef W_SPI_CTRL
`define W_SPI_CTRL 2
`endif
`ifndef MT
`define MT 2'd1
`endif
`ifndef MF
`define MF 2'd2
`endif
`ifndef W_REG
`define W_REG 5
`endif

module tb_spi_cp0_master;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [`W_SPI_CTRL-1:0] ctrl;
    logic [`W_REG-1:0]      addr;
    logic [31:0]            wd;
    logic [31:0]            data_out;
    logic                   sclk, mosi, miso;
    logic [1:0]             cs_n;
    logic                   busy;
    logic                   loop_ext, miso_val;

    int checks = 0;
    int failures = 0;

    assign miso = loop_ext ? mosi : miso_val;

    spi_cp0_master #(.W_DATA(32), .W_FRAME(8), .DEPTH(4), .N_CS(2)) dut (
        .clk(clk), .rst(rst), .ctrl(ctrl), .addr(addr), .wd(wd),
        .data_out(data_out), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cs_n(cs_n), .busy(busy)
    );

    always #5 clk = ~clk;

    // Pin monitor: busy-window length, sclk toggle statistics, cs_n low runs.
    int cyc = 0, busy_runs = 0, b_len = 0, tog = 0, min_iv = 0, max_iv = 0, last_tog = -1;
    int fr_len = 0, fr_tog = 0, fr_min = 0, fr_max = 0;
    int cs_cnt [2] = '{0, 0};
    int cs_last [2] = '{0, 0};
    int cs_runs [2] = '{0, 0};
    bit in_busy = 1'b0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (busy === 1'b1) begin
            if (!in_busy) begin
                in_busy = 1'b1; b_len = 0; tog = 0; min_iv = 1000000; max_iv = 0; last_tog = -1;
            end
            b_len++;
            if (sclk !== prev_sclk) begin
                if (last_tog >= 0) begin
                    if (cyc - last_tog < min_iv) min_iv = cyc - last_tog;
                    if (cyc - last_tog > max_iv) max_iv = cyc - last_tog;
                end
                last_tog = cyc;
                tog++;
            end
        end else if (in_busy) begin
            in_busy = 1'b0; fr_len = b_len; fr_tog = tog; fr_min = min_iv; fr_max = max_iv;
            busy_runs++;
        end
        prev_sclk = sclk;
        for (int i = 0; i < 2; i++) begin
            if (cs_n[i] === 1'b0) cs_cnt[i]++;
            else if (cs_cnt[i] != 0) begin
                cs_last[i] = cs_cnt[i]; cs_cnt[i] = 0; cs_runs[i]++;
            end
        end
    end

    task automatic mt_write(input logic [`W_REG-1:0] a, input logic [31:0] d);
        @(negedge clk);
        ctrl = `MT; addr = a; wd = d;
        @(posedge clk); #1;
        ctrl = '0; wd = '0;
    endtask

    task automatic mf_read(input logic [`W_REG-1:0] a, output logic [31:0] d);
        @(negedge clk);
        ctrl = `MF; addr = a;
        #1 d = data_out;
        @(posedge clk); #1;
        ctrl = '0;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #2;
            if (busy_runs >= target) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset;
        logic [31:0] r;
        rst = 1'b1; ctrl = '0; addr = '0; wd = '0; loop_ext = 1'b0; miso_val = 1'b1;
        idle_cycles(3);
        checks++;
        if ({sclk, mosi, cs_n, busy} !== 5'b00110 || data_out !== 32'd0) begin
            failures++;
            $display("FAIL reset_pins: sclk=%b mosi=%b cs_n=%b busy=%b data_out=%h, required 0 0 11 0 0",
                     sclk, mosi, cs_n, busy, data_out);
        end
        @(negedge clk) rst = 1'b0;
        mf_read(4, r);
        checks++;
        if (r !== 32'h14) begin failures++; $display("FAIL reset_status: got %h required 00000014", r); end
        mf_read(0, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL reset_ctrl: got %h required 00000000", r); end
        mf_read(1, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL reset_div: got %h required 00000000", r); end
    endtask

    task automatic test_regs;
        logic [31:0] r, exp_ctrl;
`ifdef SPI_LOOPBACK_EN
        exp_ctrl = 32'hF6;
`else
        exp_ctrl = 32'h76;
`endif
        mt_write(0, 32'hFFFF_FFF6);
        mf_read(0, r);
        checks++;
        if (r !== exp_ctrl) begin failures++; $display("FAIL ctrl_rw: got %h required %h", r, exp_ctrl); end
        mt_write(1, 32'h0000_01AB);
        mf_read(1, r);
        checks++;
        if (r !== 32'hAB) begin failures++; $display("FAIL div_rw: got %h required 000000ab", r); end
        mt_write(7, 32'hFFFF_FFFF);
        mf_read(7, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL unlisted_addr: got %h required 00000000", r); end
        mt_write(0, 32'h0);
        mt_write(1, 32'h0);
    endtask

    task automatic test_mode0;
        logic [31:0] r;
        logic [7:0] cap;
        logic prev;
        int first_low, nrise, base;
        bit ok;
        loop_ext = 1'b0; miso_val = 1'b1;
        mt_write(0, 32'h01);
        base = busy_runs; cap = '0; nrise = 0; first_low = 0; prev = sclk;
        mt_write(2, 32'hA5);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (cs_n[0] === 1'b0 && first_low == 0) first_low = c;
            if (sclk === 1'b1 && prev === 1'b0) begin cap = {cap[6:0], mosi}; nrise++; end
            prev = sclk;
            if (first_low != 0 && busy === 1'b0) break;
        end
        wait_frames(base + 1, 20, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL m0_timeout: frame end not seen, required within 20 cycles"); end
        checks++;
        if (first_low != 1) begin failures++; $display("FAIL m0_latency: cs_n low %0d cycles after write edge, required 1", first_low); end
        checks++;
        if (cs_last[0] != 18) begin failures++; $display("FAIL m0_cs_len: got %0d required 18", cs_last[0]); end
        checks++;
        if (nrise != 8 || cap !== 8'hA5) begin
            failures++; $display("FAIL m0_mosi: rises=%0d bits=%h required 8 a5", nrise, cap);
        end
        mf_read(3, r);
        checks++;
        if (r !== 32'hFF) begin failures++; $display("FAIL m0_rx: got %h required 000000ff", r); end
        mf_read(4, r);
        checks++;
        if (r !== 32'h14) begin failures++; $display("FAIL m0_status: got %h required 00000014", r); end
    endtask

    task automatic test_modes;
        logic [31:0] r;
        logic cpol;
        int base;
        bit ok;
        loop_ext = 1'b1;
        mt_write(1, 32'h3);
        for (int m = 1; m <= 3; m++) begin
            cpol = (m >= 2);
            mt_write(0, 32'(1 + (cpol ? 2 : 0) + ((m % 2 == 1) ? 4 : 0)));
            idle_cycles(2);
            checks++;
            if (sclk !== cpol) begin failures++; $display("FAIL mode%0d_idle_sclk: got %b required %b", m, sclk, cpol); end
            base = busy_runs;
            mt_write(2, 32'h3C);
            wait_frames(base + 1, 120, ok);
            checks++;
            if (!ok || fr_len != 72 || fr_tog != 16 || fr_min != 4 || fr_max != 4) begin
                failures++;
                $display("FAIL mode%0d_timing: done=%0d len=%0d toggles=%0d half=%0d..%0d required 1 72 16 4..4",
                         m, ok, fr_len, fr_tog, fr_min, fr_max);
            end
            mf_read(3, r);
            checks++;
            if (r !== 32'h3C) begin failures++; $display("FAIL mode%0d_rx: got %h required 0000003c", m, r); end
            checks++;
            if (sclk !== cpol) begin failures++; $display("FAIL mode%0d_end_sclk: got %b required %b", m, sclk, cpol); end
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] r;
        logic [7:0] exp_b [3];
        int base, c0;
        bit ok;
        exp_b = '{8'h11, 8'h22, 8'h33};
        loop_ext = 1'b1;
        mt_write(1, 32'h0);
        mt_write(0, 32'h11);
        idle_cycles(1);
        base = busy_runs; c0 = cs_runs[0];
        mt_write(2, 32'h11);
        mt_write(2, 32'h22);
        mt_write(2, 32'h33);
        wait_frames(base + 1, 100, ok);
        idle_cycles(2);
        checks++;
        if (!ok || cs_last[1] != 52 || fr_len != 52 || busy_runs != base + 1) begin
            failures++;
            $display("FAIL b2b_cs1_len: done=%0d cs1_low=%0d busy_len=%0d windows=%0d required 1 52 52 1",
                     ok, cs_last[1], fr_len, busy_runs - base);
        end
        checks++;
        if (cs_runs[0] != c0) begin failures++; $display("FAIL b2b_cs0_idle: cs_n[0] fell %0d times, required 0", cs_runs[0] - c0); end
        for (int i = 0; i < 3; i++) begin
            mf_read(3, r);
            checks++;
            if (r !== 32'(exp_b[i])) begin failures++; $display("FAIL b2b_rx%0d: got %h required %h", i, r, exp_b[i]); end
        end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        int base;
        bit ok;
        loop_ext = 1'b1;
        mt_write(0, 32'h0);
        for (int i = 1; i <= 5; i++) mt_write(2, 32'(i));
        mf_read(4, r);
        checks++;
        if (r !== 32'h32) begin failures++; $display("FAIL tx_ovf_status: got %h required 00000032", r); end
        mt_write(4, 32'h20);
        mf_read(4, r);
        checks++;
        if (r !== 32'h12) begin failures++; $display("FAIL tx_ovf_clear: got %h required 00000012", r); end
        base = busy_runs;
        mt_write(0, 32'h01);
        wait_frames(base + 1, 120, ok);
        checks++;
        if (!ok || fr_len != 69) begin failures++; $display("FAIL four_frames_len: done=%0d len=%0d required 1 69", ok, fr_len); end
        mf_read(4, r);
        checks++;
        if (r !== 32'h0C) begin failures++; $display("FAIL rx_full_status: got %h required 0000000c", r); end
        base = busy_runs;
        mt_write(2, 32'h05);
        wait_frames(base + 1, 60, ok);
        mf_read(4, r);
        checks++;
        if (!ok || r !== 32'h4C) begin failures++; $display("FAIL rx_ovf_status: done=%0d got %h required 1 0000004c", ok, r); end
        for (int i = 1; i <= 5; i++) begin
            mf_read(3, r);
            checks++;
            if (r !== ((i <= 4) ? 32'(i) : 32'h0)) begin
                failures++; $display("FAIL rx_drain%0d: got %h required %h", i, r, (i <= 4) ? 32'(i) : 32'h0);
            end
        end
        mf_read(4, r);
        checks++;
        if (r !== 32'h54) begin failures++; $display("FAIL rx_empty_ovf: got %h required 00000054", r); end
        mt_write(4, 32'h40);
        mf_read(4, r);
        checks++;
        if (r !== 32'h14) begin failures++; $display("FAIL rx_ovf_clear: got %h required 00000014", r); end
    endtask

    task automatic test_abort;
        logic [31:0] r;
        loop_ext = 1'b0; miso_val = 1'b1;
        mt_write(1, 32'h3);
        mt_write(0, 32'h03);
        mt_write(2, 32'hAA);
        idle_cycles(20);
        mt_write(0, 32'h02);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL abort_pre: busy=%b required 1", busy); end
        @(posedge clk); #1;
        checks++;
        if ({busy, cs_n, sclk, mosi} !== 5'b01110) begin
            failures++; $display("FAIL abort_en: busy=%b cs_n=%b sclk=%b mosi=%b required 0 11 1 0", busy, cs_n, sclk, mosi);
        end
        idle_cycles(80);
        mf_read(4, r);
        checks++;
        if (r !== 32'h14) begin failures++; $display("FAIL abort_no_rx: got %h required 00000014", r); end
        mt_write(0, 32'h03);
        mt_write(2, 32'h55);
        idle_cycles(20);
        @(negedge clk) rst = 1'b1;
        #1;
        checks++;
        if ({busy, cs_n, sclk, mosi} !== 5'b01100) begin
            failures++; $display("FAIL abort_rst: busy=%b cs_n=%b sclk=%b mosi=%b required 0 11 0 0", busy, cs_n, sclk, mosi);
        end
        @(negedge clk) rst = 1'b0;
        mf_read(4, r);
        checks++;
        if (r !== 32'h14) begin failures++; $display("FAIL rst_status: got %h required 00000014", r); end
        mf_read(0, r);
        checks++;
        if (r !== 32'h0) begin failures++; $display("FAIL rst_ctrl: got %h required 00000000", r); end
    endtask

    initial begin
        test_reset;
        test_regs;
        test_mode0;
        test_modes;
        test_back_to_back;
        test_overflow;
        test_abort;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
